argmax_unit: RTL
================

# argmax_unit

Sequential argmax stage directly downstream of the PE array. It snapshots the signed per-column accumulators (`col_accumulator`) after the final layer's bias/accumulate pass and scans them over several cycles, `COMPARES_PER_CYCLE` columns at a time. It keeps a running maximum across output tiles, so networks with more classes than `COLS` reduce to a single class index. Columns that the PE array has forced to the most-negative value (inactive subsection) lose every comparison.

## Interface

**Parameters**
- `COLS`, 16: number of accumulator columns; a power of two.
- `ACCUMULATION_BIT_WIDTH`, 24: signed width of each accumulator.
- `COMPARES_PER_CYCLE`, 4: columns examined per scan cycle; must divide `COLS`.
- `INDEX_BIT_WIDTH`, 8: width of the global class index; must be ≥ log2(`COLS`).

**Ports**
- `clk`, in, 1: clock. Single clock domain.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: request a scan of the current tile. Ignored while `busy`.
- `first_tile`, in, 1: sampled with `start`; reinitialises the running maximum.
- `last_tile`, in, 1: sampled with `start`; produces a result when this scan ends.
- `tile_index`, in, `INDEX_BIT_WIDTH`-log2(`COLS`): sampled with `start`; upper bits of the class index.
- `col_accumulator`, in, signed `ACCUMULATION_BIT_WIDTH` × [`COLS`]: accumulators from the PE array.
- `busy`, out, 1: a scan is in progress.
- `done`, out, 1: one-cycle pulse; `argmax_index` and `argmax_value` are valid.
- `argmax_index`, out, `INDEX_BIT_WIDTH`: winning class index. Holds until the next `done`.
- `argmax_value`, out, signed `ACCUMULATION_BIT_WIDTH`: winning accumulator value. Holds until the next `done`.

## Operation

**States**
- `IDLE`: waiting for `start`.
- `SCAN`: comparing column groups.
- Transitions:
  - `IDLE`→`SCAN` on `start`.
  - `SCAN`→`IDLE` after group N-1 has been compared, where N = `COLS`/`COMPARES_PER_CYCLE`.

**Accept (`IDLE` and `start`=1)**
- Snapshot all `col_accumulator` values into an internal register.
- Latch `first_tile`, `last_tile` and `tile_index`.
- Clear the group counter to 0.
- If `first_tile`=1: set the running best to value = most negative (1 followed by zeros) and index = 0.

**SCAN cycle g**
- Group g covers snapshot columns g·P … g·P+P-1, where P = `COMPARES_PER_CYCLE`.
- Within the group, pick the maximum. Ties go to the lowest column.
- The group winner replaces the running best only if strictly greater than it. The earliest index therefore wins across groups and across tiles.
- The stored index is `tile_index`·`COLS` + column, truncated to `INDEX_BIT_WIDTH`.
- Increment the counter. The counter wraps to 0 after the last group.

**End of scan**
- If `last_tile` was latched:
  - Copy the running best to `argmax_index` and `argmax_value`.
  - Pulse `done`.
- If not: the running best persists, with no `done` pulse.

**Edge cases**
- If every column equals the most-negative value, the result is index 0 and value = most negative.
- A `start` without `first_tile` continues from the existing running best, even after an earlier `done`.

**Arithmetic**
- All comparisons are signed, at full `ACCUMULATION_BIT_WIDTH`.
- No saturation and no truncation of values.

## Timing

**Reset** (asynchronous assertion; release takes effect at the first clock edge after deassertion)
- State = `IDLE`, counter = 0, running best = most negative with index 0.
- `busy`=0, `done`=0, `argmax_index`=0, `argmax_value`=0.
- A reset during `SCAN` aborts the scan; no `done` is produced.

**Scan latency**
- `start` is sampled at edge E0. `busy` is high from E0 until edge E0+N.
- Groups are compared at edges E0+1 … E0+N.
- `done` (if `last_tile`) is registered at E0+N and is high for exactly the one cycle after E0+N. `busy` is low in that same cycle.
- A new `start` presented in the `done` cycle is accepted. Back-to-back tiles therefore have an N+1-cycle period.

**Snapshot**
- `col_accumulator` is read only at E0. Changes during `SCAN` have no effect.

**Start while busy**
- Ignored: not queued and not flagged.

## Test plan

1. **Single tile, ascending values.**
   - Stimulus: `first_tile`=`last_tile`=1, tile 0, col[c]=c−8.
   - Response: `done` at E0+4 (defaults); index 15, value 7; `busy` high for exactly 4 cycles.
2. **Ties and negatives.**
   - Stimulus: all columns −5 except col 3 and col 9 = 100.
   - Response: index 3, value 100.
3. **Multi-tile.**
   - Stimulus: tile 0 (first) max 50 at col 2; tile 1 max 50 at col 0; tile 2 (last) max 80 at col 7.
   - Response: index 39, value 80. Re-run with tile 2 max 50: index 2.
4. **Masked/minimum columns and snapshot.**
   - Stimulus: all columns 0x800000.
   - Response: index 0, value 0x800000.
   - Stimulus: change `col_accumulator` during `SCAN`.
   - Response: result unchanged from the E0 snapshot.
5. **Start while busy / back-to-back.**
   - Stimulus: assert `start` every cycle.
   - Response: scans accepted only at E0 and E0+5; each produces one `done`.
6. **Reset mid-scan.**
   - Stimulus: assert `rst` at E0+2.
   - Response: outputs immediately 0 / `IDLE`; no `done`. A following single-tile scan gives the correct result.

Source files
------------

// File: rtl/argmax_if.sv
// Handshake and data bundle between the PE-array control, the PE accumulators and the argmax stage.
interface argmax_if #(
    parameter int unsigned COLS                   = 16,
    parameter int unsigned ACCUMULATION_BIT_WIDTH = 24,
    parameter int unsigned INDEX_BIT_WIDTH        = 8
);
    localparam int unsigned TILE_W = INDEX_BIT_WIDTH - $clog2(COLS);

    logic                                     start;
    logic                                     first_tile;
    logic                                     last_tile;
    logic        [TILE_W-1:0]                 tile_index;
    logic signed [ACCUMULATION_BIT_WIDTH-1:0] col_accumulator [COLS];
    logic                                     busy;
    logic                                     done;
    logic        [INDEX_BIT_WIDTH-1:0]        argmax_index;
    logic signed [ACCUMULATION_BIT_WIDTH-1:0] argmax_value;

    modport master (
        output start, first_tile, last_tile, tile_index, col_accumulator,
        input  busy, done, argmax_index, argmax_value
    );

    modport slave (
        input  start, first_tile, last_tile, tile_index, col_accumulator,
        output busy, done, argmax_index, argmax_value
    );
endinterface

// File: rtl/argmax_unit.sv
// Sequential signed argmax over the PE-array column accumulators, scanning a few columns
// per cycle and keeping a running maximum across output tiles.
module argmax_unit #(
    parameter int unsigned COLS                   = 16,
    parameter int unsigned ACCUMULATION_BIT_WIDTH = 24,
    parameter int unsigned COMPARES_PER_CYCLE     = 4,
    parameter int unsigned INDEX_BIT_WIDTH        = 8
) (
    input logic     clk,
    input logic     rst,
    argmax_if.slave bus
);
    localparam int unsigned AW     = ACCUMULATION_BIT_WIDTH;
    localparam int unsigned IW     = INDEX_BIT_WIDTH;
    localparam int unsigned P      = COMPARES_PER_CYCLE;
    localparam int unsigned N      = COLS / COMPARES_PER_CYCLE;
    localparam int unsigned COL_W  = $clog2(COLS);
    localparam int unsigned TILE_W = IW - COL_W;
    localparam int unsigned GRP_W  = (N > 1) ? $clog2(N) : 1;

    localparam logic signed [AW-1:0] MOST_NEG = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                   state;
    logic        [GRP_W-1:0]  grp;
    logic                     last_q;
    logic        [TILE_W-1:0] tile_q;
    logic signed [AW-1:0]     best_val;
    logic        [IW-1:0]     best_idx;
    logic signed [AW-1:0]     snap [COLS];

    logic                     busy_q;
    logic                     done_q;
    logic        [IW-1:0]     index_q;
    logic signed [AW-1:0]     value_q;

    logic                     accept;
    logic                     last_grp;
    logic        [COL_W-1:0]  base_col;
    logic        [COL_W-1:0]  probe_col;
    logic        [COL_W-1:0]  grp_col;
    logic signed [AW-1:0]     grp_val;
    logic signed [AW-1:0]     next_val;
    logic        [IW-1:0]     next_idx;

    assign accept   = (state == IDLE) && bus.start;
    assign last_grp = (grp == GRP_W'(N - 1));

    // Group winner: strict '>' walking upward keeps the lowest column on ties.
    always_comb begin
        base_col  = COL_W'(32'(grp) * P);
        probe_col = base_col;
        grp_col   = base_col;
        grp_val   = snap[base_col];
        for (int j = 1; j < int'(P); j++) begin
            probe_col = base_col + COL_W'(j);
            if (snap[probe_col] > grp_val) begin
                grp_val = snap[probe_col];
                grp_col = probe_col;
            end
        end
    end

    // Running best only yields to a strictly greater value, so earlier classes win ties.
    always_comb begin
        next_val = best_val;
        next_idx = best_idx;
        if (grp_val > best_val) begin
            next_val = grp_val;
            next_idx = {tile_q, grp_col};
        end
    end

    // Accumulators are read only on the accept edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < int'(COLS); c++) begin
                snap[c] <= bus.col_accumulator[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grp      <= '0;
            last_q   <= 1'b0;
            tile_q   <= '0;
            best_val <= MOST_NEG;
            best_idx <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            index_q  <= '0;
            value_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= SCAN;
                        grp    <= '0;
                        busy_q <= 1'b1;
                        last_q <= bus.last_tile;
                        tile_q <= bus.tile_index;
                        if (bus.first_tile) begin
                            best_val <= MOST_NEG;
                            best_idx <= '0;
                        end
                    end
                end
                SCAN: begin
                    best_val <= next_val;
                    best_idx <= next_idx;
                    if (last_grp) begin
                        state  <= IDLE;
                        grp    <= '0;
                        busy_q <= 1'b0;
                        if (last_q) begin
                            done_q  <= 1'b1;
                            index_q <= next_idx;
                            value_q <= next_val;
                        end
                    end else begin
                        grp <= grp + GRP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.argmax_index = index_q;
    assign bus.argmax_value = value_q;
endmodule
